// File: rtl/multicycle_controller.sv
// Moore controller for the shared-memory multicycle datapath: fetch/decode/execute/mem/writeback.
// Optional feature: define MULTICYCLE_BLT_EN to enable the BLT (branch if less-than) instruction.
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       lessthan,
    output logic       pcen,
    output logic       irwrite,
    output logic       memwrite,
    output logic       regwrite,
    output logic       iord,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       regdst,
    output logic       memtoreg,
    output logic [3:0] alucontrol,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BLT   = 6'b000110;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11,
        S_BLTEX   = 4'd12
    } state_t;

    state_t r_state;
    state_t w_next;

    logic       w_pcwrite, w_branch, w_blt;
    logic       w_irwrite, w_memwrite, w_regwrite, w_iord, w_alusrca;
    logic [1:0] w_alusrcb, w_pcsrc;
    logic       w_regdst, w_memtoreg, w_instr_done, w_illegal;
    logic [3:0] w_alucontrol;
    logic       w_pcen;

    function automatic logic [3:0] f_funct_dec(input logic [5:0] fn);
        case (fn)
            6'b100000: f_funct_dec = ALU_ADD;
            6'b100010: f_funct_dec = ALU_SUB;
            6'b100100: f_funct_dec = ALU_AND;
            6'b100101: f_funct_dec = ALU_OR;
            6'b101010: f_funct_dec = ALU_SLT;
            default:   f_funct_dec = ALU_ADD;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_FETCH;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next       = S_FETCH;
        w_pcwrite    = 1'b0;
        w_branch     = 1'b0;
        w_blt        = 1'b0;
        w_irwrite    = 1'b0;
        w_memwrite   = 1'b0;
        w_regwrite   = 1'b0;
        w_iord       = 1'b0;
        w_alusrca    = 1'b0;
        w_alusrcb    = 2'b00;
        w_pcsrc      = 2'b00;
        w_regdst     = 1'b0;
        w_memtoreg   = 1'b0;
        w_alucontrol = ALU_ADD;
        w_instr_done = 1'b0;
        w_illegal    = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_alusrcb = 2'b01;
                w_irwrite = 1'b1;
                w_pcwrite = 1'b1;
                w_next    = S_DECODE;
            end
            S_DECODE: begin
                w_alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_RTYPEEX;
                    OP_BEQ:       w_next = S_BEQEX;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_J:         w_next = S_JEX;
`ifdef MULTICYCLE_BLT_EN
                    OP_BLT:       w_next = S_BLTEX;
`else
                    OP_BLT: begin
                        w_next    = S_FETCH;
                        w_illegal = 1'b1;
                    end
`endif
                    default: begin
                        w_next    = S_FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
                w_next    = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                w_iord = 1'b1;
                w_next = S_MEMWB;
            end
            S_MEMWB: begin
                w_memtoreg   = 1'b1;
                w_regwrite   = 1'b1;
                w_instr_done = 1'b1;
            end
            S_MEMWR: begin
                w_iord       = 1'b1;
                w_memwrite   = 1'b1;
                w_instr_done = 1'b1;
            end
            S_RTYPEEX: begin
                w_alusrca    = 1'b1;
                w_alucontrol = f_funct_dec(funct);
                w_next       = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                w_regdst     = 1'b1;
                w_regwrite   = 1'b1;
                w_instr_done = 1'b1;
            end
            S_BEQEX: begin
                w_alusrca    = 1'b1;
                w_alucontrol = ALU_SUB;
                w_pcsrc      = 2'b01;
                w_branch     = 1'b1;
                w_instr_done = 1'b1;
            end
            S_ADDIEX: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
                w_next    = S_ADDIWB;
            end
            S_ADDIWB: begin
                w_regwrite   = 1'b1;
                w_instr_done = 1'b1;
            end
            S_JEX: begin
                w_pcsrc      = 2'b10;
                w_pcwrite    = 1'b1;
                w_instr_done = 1'b1;
            end
`ifdef MULTICYCLE_BLT_EN
            S_BLTEX: begin
                w_alusrca    = 1'b1;
                w_alucontrol = ALU_SLT;
                w_pcsrc      = 2'b01;
                w_blt        = 1'b1;
                w_instr_done = 1'b1;
            end
`endif
            // Unreachable encodings recover to FETCH with every control low.
            default: begin
                w_alucontrol = 4'b0000;
                w_next       = S_FETCH;
            end
        endcase
    end

    // Without the BLT feature w_blt stays low, so lessthan never reaches pcen.
    assign w_pcen = w_pcwrite | (w_branch & zero) | (w_blt & lessthan);

    // Reset low forces every output to zero regardless of the registered state.
    assign pcen       = reset & w_pcen;
    assign irwrite    = reset & w_irwrite;
    assign memwrite   = reset & w_memwrite;
    assign regwrite   = reset & w_regwrite;
    assign iord       = reset & w_iord;
    assign alusrca    = reset & w_alusrca;
    assign alusrcb    = reset ? w_alusrcb : 2'b00;
    assign pcsrc      = reset ? w_pcsrc : 2'b00;
    assign regdst     = reset & w_regdst;
    assign memtoreg   = reset & w_memtoreg;
    assign alucontrol = reset ? w_alucontrol : 4'b0000;
    assign instr_done = reset & w_instr_done;
    assign illegal_op = reset & w_illegal;
    assign state      = reset ? r_state : 4'd0;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expected control vectors queued and compared.
// Honours MULTICYCLE_BLT_EN the same way as the design.
module tb_multicycle_controller;

    logic       clk, reset;
    logic [5:0] op, funct;
    logic       zero, lessthan;
    logic       pcen, irwrite, memwrite, regwrite, iord, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic       regdst, memtoreg;
    logic [3:0] alucontrol;
    logic       instr_done, illegal_op;
    logic [3:0] state;

    localparam logic [3:0] ADD = 4'b0010;
    localparam logic [3:0] SUB = 4'b0110;
    localparam logic [3:0] SLT = 4'b0111;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        logic [21:0] v;
    } exp_t;
    exp_t sbq[$];

    multicycle_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .lessthan(lessthan),
        .pcen(pcen), .irwrite(irwrite), .memwrite(memwrite), .regwrite(regwrite),
        .iord(iord), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
        .regdst(regdst), .memtoreg(memtoreg), .alucontrol(alucontrol),
        .instr_done(instr_done), .illegal_op(illegal_op), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [21:0] w_obs = {pcen, irwrite, memwrite, regwrite, iord, alusrca, alusrcb, pcsrc,
                         regdst, memtoreg, alucontrol, instr_done, illegal_op, state};

    // Field order: pcen irwrite memwrite regwrite iord alusrca alusrcb pcsrc regdst memtoreg alu done ill state
    function automatic logic [21:0] mkv(input logic pe, input logic irw, input logic mw,
                                        input logic rw, input logic io, input logic asa,
                                        input logic [1:0] asb, input logic [1:0] pcs,
                                        input logic rd, input logic m2r, input logic [3:0] alu,
                                        input logic dn, input logic il, input logic [3:0] st);
        mkv = {pe, irw, mw, rw, io, asa, asb, pcs, rd, m2r, alu, dn, il, st};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [21:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        sbq.push_back(e);
    endtask

    // Compare one queued vector per cycle, sampling 1 time unit after the rising edge.
    task automatic drain();
        exp_t e;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            check_val(e.tag, {10'd0, w_obs}, {10'd0, e.v});
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_fetch_decode(input string name, input logic ill);
        push({name, "_fetch"},  mkv(1,1,0,0,0,0,2'b01,2'b00,0,0,ADD,0,0,4'd0));
        push({name, "_decode"}, mkv(0,0,0,0,0,0,2'b11,2'b00,0,0,ADD,0,ill,4'd1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; op = 6'd0; funct = 6'd0; zero = 1'b0; lessthan = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_val("reset_low_outs", {10'd0, w_obs}, 32'd0);
        end
        reset = 1'b1;
        #1;
        check_val("after_release", {10'd0, w_obs},
                  {10'd0, mkv(1,1,0,0,0,0,2'b01,2'b00,0,0,ADD,0,0,4'd0)});

        // Load word: 5 cycles
        op = 6'b100011;
        push_fetch_decode("lw", 0);
        push("lw_memadr", mkv(0,0,0,0,0,1,2'b10,2'b00,0,0,ADD,0,0,4'd2));
        push("lw_memrd",  mkv(0,0,0,0,1,0,2'b00,2'b00,0,0,ADD,0,0,4'd3));
        push("lw_memwb",  mkv(0,0,0,1,0,0,2'b00,2'b00,0,1,ADD,1,0,4'd4));
        drain();

        // Branch equal, taken then not taken
        op = 6'b000100; zero = 1'b1;
        push_fetch_decode("beq_t", 0);
        push("beq_t_ex", mkv(1,0,0,0,0,1,2'b00,2'b01,0,0,SUB,1,0,4'd8));
        drain();
        zero = 1'b0;
        push_fetch_decode("beq_nt", 0);
        push("beq_nt_ex", mkv(0,0,0,0,0,1,2'b00,2'b01,0,0,SUB,1,0,4'd8));
        drain();

        // R-type slt and sub
        op = 6'b000000; funct = 6'b101010;
        push_fetch_decode("slt", 0);
        push("slt_ex", mkv(0,0,0,0,0,1,2'b00,2'b00,0,0,SLT,0,0,4'd6));
        push("slt_wb", mkv(0,0,0,1,0,0,2'b00,2'b00,1,0,ADD,1,0,4'd7));
        drain();
        funct = 6'b100010;
        push_fetch_decode("sub", 0);
        push("sub_ex", mkv(0,0,0,0,0,1,2'b00,2'b00,0,0,SUB,0,0,4'd6));
        push("sub_wb", mkv(0,0,0,1,0,0,2'b00,2'b00,1,0,ADD,1,0,4'd7));
        drain();
        funct = 6'b100101;
        push_fetch_decode("or", 0);
        push("or_ex", mkv(0,0,0,0,0,1,2'b00,2'b00,0,0,4'b0001,0,0,4'd6));
        push("or_wb", mkv(0,0,0,1,0,0,2'b00,2'b00,1,0,ADD,1,0,4'd7));
        drain();

        // Add immediate and jump
        op = 6'b001000;
        push_fetch_decode("addi", 0);
        push("addi_ex", mkv(0,0,0,0,0,1,2'b10,2'b00,0,0,ADD,0,0,4'd9));
        push("addi_wb", mkv(0,0,0,1,0,0,2'b00,2'b00,0,0,ADD,1,0,4'd10));
        drain();
        op = 6'b000010;
        push_fetch_decode("j", 0);
        push("j_ex", mkv(1,0,0,0,0,0,2'b00,2'b10,0,0,ADD,1,0,4'd11));
        drain();

        // Branch less-than
        op = 6'b000110; lessthan = 1'b1;
`ifdef MULTICYCLE_BLT_EN
        push_fetch_decode("blt", 0);
        push("blt_ex", mkv(1,0,0,0,0,1,2'b00,2'b01,0,0,SLT,1,0,4'd12));
`else
        push_fetch_decode("blt_ill", 1);
`endif
        drain();
        lessthan = 1'b0;

        // Always-illegal opcode
        op = 6'b111111;
        push_fetch_decode("ill", 1);
        drain();

        // Store word aborted by reset in MEMADR
        op = 6'b101011;
        push_fetch_decode("sw", 0);
        drain();
        check_val("sw_memadr", {10'd0, w_obs},
                  {10'd0, mkv(0,0,0,0,0,1,2'b10,2'b00,0,0,ADD,0,0,4'd2)});
        reset = 1'b0;
        #1;
        check_val("abort_outs", {10'd0, w_obs}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check_val("abort_memwrite", {31'd0, memwrite}, 32'd0);
            check_val("abort_state", {28'd0, dut.r_state}, 32'd0);
        end
        reset = 1'b1;
        #1;
        check_val("abort_state_rel", {28'd0, state}, 32'd0);

        // Normal store after restart
        push_fetch_decode("sw2", 0);
        push("sw2_memadr", mkv(0,0,0,0,0,1,2'b10,2'b00,0,0,ADD,0,0,4'd2));
        push("sw2_memwr",  mkv(0,0,1,0,1,0,2'b00,2'b00,0,0,ADD,1,0,4'd5));
        push("sw2_next",   mkv(1,1,0,0,0,0,2'b01,2'b00,0,0,ADD,0,0,4'd0));
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
